counter: RTL and testbench

// - WIDTH-bit synchronous up/down binary counter, default 4 bits.
// - General-purpose count/sequence source for datapath and test structures.
// - up_down selects the direction on every clock edge.
// - Wraps modulo 2**WIDTH in both directions.
// - tc flags the wrap edge so counters can be cascaded.
//

---
 rtl/counter.sv | 37 +++
 tb/tb_counter.sv | 106 ++++++++++
 2 files changed

// File: rtl/counter.sv
// WIDTH-bit synchronous up/down counter, wraps modulo 2**WIDTH; tc flags the wrap edge.
// Latency: count updates one clk edge after rst/up_down are sampled; tc is combinational.
// Backpressure: none; the counter advances on every edge.
module counter #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    // Reset wins over counting and ignores up_down on that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= RESET_VAL;
        end else if (up_down) begin
            count <= count + ONE;
        end else begin
            count <= count - ONE;
        end
    end

    // Gated by rst so tc stays low during reset even while count is still unknown.
    always_comb begin
        tc = 1'b0;
        if (rst) begin
            tc = up_down ? (count == MAX_VAL) : (count == '0);
        end
    end

endmodule

// File: tb/tb_counter.sv
module tb_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up_down = 1'b0;
    logic [3:0] count;
    logic       tc;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] exp_q[$];
    logic [3:0] model = 4'd0;

    counter #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
        .clk    (clk),
        .rst    (rst),
        .up_down(up_down),
        .count  (count),
        .tc     (tc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One clock step: drive at negedge, check tc before the edge, check count after it.
    task automatic apply(input logic r, input logic ud, input string tag);
        logic       exp_tc;
        logic [3:0] exp_cnt;
        logic [3:0] got_exp;
        rst     = r;
        up_down = ud;
        #1;
        exp_tc = r && ((ud && model == 4'd15) || (!ud && model == 4'd0));
        vectors++;
        assert (tc === exp_tc) else begin
            miscompares++;
            $error("FAIL %s tc: observed %b expected %b (model count %0d)", tag, tc, exp_tc, model);
        end
        if (!r)      exp_cnt = 4'd0;
        else if (ud) exp_cnt = model + 4'd1;
        else         exp_cnt = model - 4'd1;
        exp_q.push_back(exp_cnt);
        @(posedge clk);
        #1;
        got_exp = exp_q.pop_front();
        vectors++;
        assert (count === got_exp) else begin
            miscompares++;
            $error("FAIL %s count: observed %0d expected %0d", tag, count, got_exp);
        end
        model = got_exp;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Reset, including a held reset.
        apply(1'b0, 1'b0, "reset");
        apply(1'b0, 1'b1, "reset_hold");

        // Down count from 0 wraps to 15.
        repeat (3) apply(1'b1, 1'b0, "down");

        // Up count through the 15 -> 0 wrap.
        repeat (5) apply(1'b1, 1'b1, "up_wrap");

        // Climb to 5, then switch direction: next is 4.
        repeat (3) apply(1'b1, 1'b1, "up_to5");
        apply(1'b1, 1'b0, "dir_switch");
        apply(1'b1, 1'b1, "dir_back");

        // Mid-count reset at 9, then resume.
        apply(1'b0, 1'b1, "reset2");
        repeat (9) apply(1'b1, 1'b1, "up_to9");
        apply(1'b0, 1'b1, "mid_reset");
        apply(1'b1, 1'b1, "resume");

        // Reset while count is at 15 counting up: tc must stay masked.
        repeat (14) apply(1'b1, 1'b1, "up_to15");
        apply(1'b0, 1'b1, "reset_mask");

        // Long run: 16 up, 15 down from reset.
        repeat (16) apply(1'b1, 1'b1, "long_up");
        repeat (15) apply(1'b1, 1'b0, "long_down");

        // Random direction walk.
        repeat (40) apply(1'b1, 1'($urandom_range(0, 1)), "random");

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard: observed %0d leftover entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
